// File: rtl/intersection_controller.sv
// Actuated NS/EW intersection sequencer with min/max green, yellow and all-red clearance.
// Optional pedestrian walk phase enabled by defining INTERSECTION_PED_EN.
module intersection_controller #(
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        ALLRED_A  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_B  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        PED_WALK  = 3'd6,
        ILLEGAL   = 3'd7
    } state_e;

    localparam logic [CNT_W-1:0] GMIN_L   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_L   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YELLOW_L = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_L = CNT_W'(ALLRED_T - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ns_pend_q, ns_pend_d;
    logic             ew_pend_q, ew_pend_d;
    logic             ped_pend_q;
    logic             in_green;

`ifdef INTERSECTION_PED_EN
    localparam logic [CNT_W-1:0] WALK_L = CNT_W'(WALK_T - 1);
    logic ped_pend_d;
    // ret_q: 0 = walk returns to NS green, 1 = walk returns to EW green
    logic ret_q, ret_d;
`else
    logic unused_ped;
    assign unused_ped = ped_req;
    assign ped_pend_q = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
`ifdef INTERSECTION_PED_EN
        ret_d   = ret_q;
`endif
        case (state_q)
            ALLRED_A: if (timer_q == ALLRED_L) begin
`ifdef INTERSECTION_PED_EN
                if (ped_pend_q) begin
                    state_d = PED_WALK;
                    ret_d   = 1'b0;
                end else
`endif
                    state_d = NS_GREEN;
            end
            NS_GREEN: if ((ew_pend_q | ped_pend_q) && (timer_q >= GMIN_L) &&
                          (!ns_req || (timer_q >= GMAX_L)))
                state_d = NS_YELLOW;
            NS_YELLOW: if (timer_q == YELLOW_L) state_d = ALLRED_B;
            ALLRED_B: if (timer_q == ALLRED_L) begin
`ifdef INTERSECTION_PED_EN
                if (ped_pend_q) begin
                    state_d = PED_WALK;
                    ret_d   = 1'b1;
                end else
`endif
                    state_d = EW_GREEN;
            end
            EW_GREEN: if ((ns_pend_q | ped_pend_q) && (timer_q >= GMIN_L) &&
                          (!ew_req || (timer_q >= GMAX_L)))
                state_d = EW_YELLOW;
            EW_YELLOW: if (timer_q == YELLOW_L) state_d = ALLRED_A;
`ifdef INTERSECTION_PED_EN
            PED_WALK: if (timer_q == WALK_L) state_d = ret_q ? EW_GREEN : NS_GREEN;
`endif
            default: state_d = ALLRED_A;
        endcase
    end

    // Green timers saturate so an uncontested green can rest indefinitely.
    assign in_green = (state_q == NS_GREEN) || (state_q == EW_GREEN);

    always_comb begin
        if (state_d != state_q)
            timer_d = '0;
        else if (in_green && (timer_q >= GMAX_L))
            timer_d = timer_q;
        else
            timer_d = timer_q + CNT_W'(1);
    end

    // Entering a green clears its own request, overriding a same-edge set.
    assign ns_pend_d = (ns_pend_q | ns_req) & ~((state_d == NS_GREEN) && (state_q != NS_GREEN));
    assign ew_pend_d = (ew_pend_q | ew_req) & ~((state_d == EW_GREEN) && (state_q != EW_GREEN));
`ifdef INTERSECTION_PED_EN
    assign ped_pend_d = (ped_pend_q | ped_req) & ~((state_d == PED_WALK) && (state_q != PED_WALK));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ALLRED_A;
            timer_q    <= '0;
            ns_pend_q  <= 1'b0;
            ew_pend_q  <= 1'b0;
`ifdef INTERSECTION_PED_EN
            ped_pend_q <= 1'b0;
            ret_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ns_pend_q  <= ns_pend_d;
            ew_pend_q  <= ew_pend_d;
`ifdef INTERSECTION_PED_EN
            ped_pend_q <= ped_pend_d;
            ret_q      <= ret_d;
`endif
        end
    end

    always_comb begin
        ns_red    = 1'b1;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b1;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        walk      = 1'b0;
        case (state_q)
            NS_GREEN:  begin ns_red = 1'b0; ns_green  = 1'b1; end
            NS_YELLOW: begin ns_red = 1'b0; ns_yellow = 1'b1; end
            EW_GREEN:  begin ew_red = 1'b0; ew_green  = 1'b1; end
            EW_YELLOW: begin ew_red = 1'b0; ew_yellow = 1'b1; end
`ifdef INTERSECTION_PED_EN
            PED_WALK:  walk = 1'b1;
`endif
            default: ;
        endcase
    end

    assign phase = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller: vector table, directed corner
// sequences and randomized stimulus against a behavioural reference model.
module tb_intersection_controller;
    localparam int GREEN_MIN = 8;
    localparam int GREEN_MAX = 20;
    localparam int YELLOW_T  = 3;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 6;
`ifdef INTERSECTION_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_r, ns_r, ew_r, ped_r;
    logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
    logic [2:0] phase;

    int n_vec  = 0;
    int n_fail = 0;

    // reference model state: phase number, cycles spent in phase, pending flags
    int m_ph = 0;
    int m_t  = 0;
    bit m_nsp, m_ewp, m_pedp, m_ret;
    int prev_ph = 0;

    always #5 clk = ~clk;

    intersection_controller #(
        .CNT_W(8), .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
        .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
    ) dut (
        .clk(clk), .rst(rst_r), .ns_req(ns_r), .ew_req(ew_r), .ped_req(ped_r),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .walk(walk), .phase(phase)
    );

    typedef struct {
        bit         rst, ns, ew, ped;
        logic [2:0] ph;
        logic [6:0] lamps;
    } vec_t;

    vec_t tbl[6];

    // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}
    function automatic logic [6:0] lamps_of(int ph);
        case (ph)
            1:       return 7'b0011000;
            2:       return 7'b0101000;
            4:       return 7'b1000010;
            5:       return 7'b1000100;
            6:       return 7'b1001001;
            default: return 7'b1001000;
        endcase
    endfunction

    function automatic int dur_of(int ph);
        case (ph)
            0, 3:    return ALLRED_T;
            2, 5:    return YELLOW_T;
            6:       return WALK_T;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int nx;
        if (rst_r) begin
            m_ph = 0; m_t = 0; m_nsp = 0; m_ewp = 0; m_pedp = 0; m_ret = 0;
            return;
        end
        nx = m_ph;
        if (m_ph == 1) begin
            if ((m_ewp || m_pedp) && m_t >= GREEN_MIN - 1 && (!ns_r || m_t >= GREEN_MAX - 1)) nx = 2;
        end else if (m_ph == 4) begin
            if ((m_nsp || m_pedp) && m_t >= GREEN_MIN - 1 && (!ew_r || m_t >= GREEN_MAX - 1)) nx = 5;
        end else if (m_ph >= 7 || (m_ph == 6 && !PED)) begin
            nx = 0;
        end else if (m_t + 1 >= dur_of(m_ph)) begin
            case (m_ph)
                0: if (m_pedp) begin nx = 6; m_ret = 0; end else nx = 1;
                2: nx = 3;
                3: if (m_pedp) begin nx = 6; m_ret = 1; end else nx = 4;
                5: nx = 0;
                6: nx = m_ret ? 4 : 1;
                default: nx = 0;
            endcase
        end
        m_nsp  = (m_nsp || ns_r) && !(nx == 1 && m_ph != 1);
        m_ewp  = (m_ewp || ew_r) && !(nx == 4 && m_ph != 4);
        m_pedp = PED && (m_pedp || ped_r) && !(nx == 6 && m_ph != 6);
        m_t    = (nx != m_ph) ? 0 : m_t + 1;
        m_ph   = nx;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model", {phase, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk},
              {3'(m_ph), lamps_of(m_ph)});
        check("two_greens", int'(ns_green & ew_green), 0);
        if (!rst_r && prev_ph == 2 && phase != 3'd2) check("ns_yellow_to_allred", phase, 3);
        if (!rst_r && prev_ph == 5 && phase != 3'd5) check("ew_yellow_to_allred", phase, 0);
        prev_ph = phase;
    endtask

    task automatic wait_phase(input int ph, input int budget);
        int k = 0;
        while (phase != 3'(ph) && k < budget) begin
            tick();
            k++;
        end
        check("wait_phase", phase, ph);
    endtask

    // Counts cycles the current phase persists with inputs held.
    task automatic dur(input int ph, output int n);
        n = 0;
        while (phase == 3'(ph) && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic rest(input int ph, input int cycles, output int ok);
        ok = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (phase == 3'(ph) && !walk) ok++;
        end
    endtask

    initial begin
        int n, ok;
        rst_r = 1'b1; ns_r = 1'b0; ew_r = 1'b0; ped_r = 1'b0;

        tbl[0] = '{1, 0, 0, 0, 3'd0, 7'b1001000};
        tbl[1] = '{1, 0, 0, 0, 3'd0, 7'b1001000};
        tbl[2] = '{0, 0, 0, 0, 3'd1, 7'b0011000};
        tbl[3] = '{0, 0, 0, 0, 3'd1, 7'b0011000};
        tbl[4] = '{0, 0, 0, 1, 3'd1, 7'b0011000};
        tbl[5] = '{0, 1, 0, 0, 3'd1, 7'b0011000};

        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            rst_r = tbl[i].rst; ns_r = tbl[i].ns; ew_r = tbl[i].ew; ped_r = PED ? 1'b0 : tbl[i].ped;
            tick();
            check("tbl_phase", phase, tbl[i].ph);
            check("tbl_lamps", {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk},
                  tbl[i].lamps);
        end
        ns_r = 1'b0;

        // NS green rests with no competing demand
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (phase == 3'd1 && ew_red && ns_green) ok++;
        end
        check("rest_ns_100", ok, 100);

        // ew pulse at timer=2 of a fresh NS green: 8 green, 3 yellow, 1 all-red
        rst_r = 1'b1; tick(); tick(); rst_r = 1'b0;
        tick();
        check("ns_entry", phase, 1);
        tick(); tick();
        ew_r = 1'b1; tick(); ew_r = 1'b0;
        dur(1, n); check("ns_green_len", n + 3, GREEN_MIN);
        dur(2, n); check("ns_yellow_len", n, YELLOW_T);
        dur(3, n); check("allred_b_len", n, ALLRED_T);
        check("ew_entry", phase, 4);
        rest(4, 30, ok); check("rest_ew", ok, 30);
        ns_r = 1'b1; tick(); ns_r = 1'b0;
        wait_phase(1, 40);
        rest(1, 30, ok); check("ew_pend_cleared", ok, 30);

        // ns held, ew pulse at NS entry: green runs to GREEN_MAX
        ew_r = 1'b1; tick(); ew_r = 1'b0;
        wait_phase(4, 40);
        ns_r = 1'b1;
        wait_phase(1, 40);
        ew_r = 1'b1; tick(); ew_r = 1'b0;
        dur(1, n); check("ns_green_max", n + 1, GREEN_MAX);
        check("max_to_yellow", phase, 2);

        // ns held then dropped at timer=12: yellow on the next edge
        wait_phase(4, 40);
        wait_phase(1, 40);
        ew_r = 1'b1; tick(); ew_r = 1'b0;
        repeat (11) tick();
        check("ns_hold_t12", phase, 1);
        ns_r = 1'b0; tick();
        check("ns_drop_exit", phase, 2);

        // reset during EW_YELLOW with pending requests
        wait_phase(4, 40);
        ns_r = 1'b1; tick(); ns_r = 1'b0;
        wait_phase(5, 40);
        ns_r = 1'b1; ew_r = 1'b1; tick(); ns_r = 1'b0; ew_r = 1'b0;
        check("still_ew_yellow", phase, 5);
        rst_r = 1'b1; tick(); rst_r = 1'b0;
        check("rst_phase", phase, 0);
        tick();
        check("rst_resume", phase, 1);
        rest(1, 40, ok); check("rst_flags_clear", ok, 40);

        // pedestrian request while resting in NS green
        ped_r = 1'b1; tick(); ped_r = 1'b0;
`ifdef INTERSECTION_PED_EN
        wait_phase(2, 10);
        dur(2, n); check("ped_yellow_len", n, YELLOW_T);
        dur(3, n); check("ped_allred_len", n, ALLRED_T);
        check("ped_phase", phase, 6);
        check("ped_walk", walk, 1);
        dur(6, n); check("walk_len", n, WALK_T);
        check("walk_to_ew", phase, 4);
`else
        rest(1, 40, ok); check("ped_ignored", ok, 40);
`endif

        // randomized stimulus against the reference model
        for (int i = 0; i < 4000; i++) begin
            rst_r = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 9) == 0) ns_r = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) ew_r = $urandom_range(0, 1);
            ped_r = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/intersection_controller.md
Name: intersection_controller

Overview:
Actuated two-direction intersection sequencer for the north-south (NS) and east-west (EW) approaches. Drives one red/yellow/green lamp set per direction, so the two approaches of a crossing are sequenced safely. Latches vehicle sensor requests, enforces minimum and maximum green times, and inserts yellow and all-red clearance intervals. Optionally schedules a pedestrian walk phase.

Parameters:
CNT_W, 8, phase timer width; every duration parameter is at most 2**CNT_W-1
GREEN_MIN, 8, minimum green cycles (>=1)
GREEN_MAX, 20, maximum green cycles while own request persists (>=GREEN_MIN)
YELLOW_T, 3, yellow cycles (>=1)
ALLRED_T, 1, all-red clearance cycles (>=1)
WALK_T, 6, pedestrian walk cycles (>=1; used only with the feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
ns_req  in  1  NS vehicle sensor; level, sampled each edge
ew_req  in  1  EW vehicle sensor
ped_req  in  1  pedestrian button (feature only)
ns_red / ns_yellow / ns_green  out  1 each  NS lamps
ew_red / ew_yellow / ew_green  out  1 each  EW lamps
walk  out  1  pedestrian walk lamp
phase  out  3  current state code (debug/observability)

Behaviour:
- One clock, clk. rst is synchronous and active-high. While rst is sampled high: phase=0 (ALLRED_A), timer=0, all pending flags=0. Lamps then show ns_red=ew_red=1, all other lamp outputs 0, and walk=0.
- State codes: 0 ALLRED_A (leads to NS), 1 NS_GREEN, 2 NS_YELLOW, 3 ALLRED_B (leads to EW), 4 EW_GREEN, 5 EW_YELLOW, 6 PED_WALK. Code 7 is illegal and returns to 0 on the next edge.
- Lamps are a pure decode of the state register and change on the same edge as phase. In every state exactly one lamp per direction is on. A direction's green or yellow lamp is on only while the other direction is red.
- Timer clears to 0 on every state entry and increments each cycle. A fixed-length state of N cycles exits on the edge where timer==N-1. In green states the timer saturates at GREEN_MAX-1.
- Pending flags: ns_pend/ew_pend are set when ns_req/ew_req is sampled high. Each flag clears on the edge that enters its own green. If set and clear coincide on the same edge, clear wins.
- Demand for NS green exit = ew_pend or ped_pend. Demand for EW green exit = ns_pend or ped_pend.
- NS_GREEN exits to NS_YELLOW when demand is present and timer>=GREEN_MIN-1 and (ns_req==0 or timer>=GREEN_MAX-1). With no demand the controller rests in green indefinitely. EW_GREEN follows the same rule with the directions swapped.
- NS_YELLOW lasts YELLOW_T cycles, then goes to ALLRED_B. EW_YELLOW lasts YELLOW_T cycles, then goes to ALLRED_A.
- ALLRED_A lasts ALLRED_T cycles, then goes to NS_GREEN. ALLRED_B lasts ALLRED_T cycles, then goes to EW_GREEN. With the feature, both are diverted to PED_WALK when ped_pend is set.
- Reset mid-phase overrides everything: next phase is 0 regardless of current state.

Optional Feature:
Macro: INTERSECTION_PED_EN
- Defined: ped_req sets ped_pend, which clears on entry to PED_WALK.
- From ALLRED_A or ALLRED_B with ped_pend set, the next state is PED_WALK. A 1-bit return register records the direction that state was leading to (ALLRED_A leads to NS, ALLRED_B leads to EW).
- PED_WALK: both directions red, walk=1, duration WALK_T cycles, then enters the recorded green.
- Not defined: ped_req is ignored, ped_pend stays constant 0, walk is tied 0, and state 6 is unreachable (treated as illegal).

Test Plan:
1. rst high 2 cycles, then all requests 0 -> phase=0 for 1 cycle, then phase=1 with ns_green=1; stays there for 100 cycles; ew_red=1 throughout.
2. Resting in NS_GREEN, ns_req=0, one-cycle ew_req pulse at timer=2 -> NS_GREEN totals 8 cycles, NS_YELLOW 3, ALLRED_B 1, then EW_GREEN; ew_pend=0 after entry.
3. ns_req held 1, ew_req pulsed at NS_GREEN entry -> NS_GREEN lasts exactly 20 cycles, then NS_YELLOW.
4. ns_req held 1 with ew pending, ns_req dropped at timer=12 -> NS_YELLOW entered on the following edge. Check that no state ever has both greens on, and that yellow is always followed by all-red.
5. rst asserted for one cycle during EW_YELLOW with ns_pend=1 -> next edge phase=0, all flags 0; sequence then resumes as in test 1.
6. With INTERSECTION_PED_EN, ped_req pulse during NS_GREEN -> after NS_YELLOW(3) and ALLRED_B(1): phase=6, walk=1 for 6 cycles, then EW_GREEN. Without the macro, the same stimulus keeps walk=0 and behaves as test 1.
